ahb_split_arbiter: RTL and testbench
====================================

Name: ahb_split_arbiter

Overview:
AHB bus arbiter that sits upstream of the slaves and decides which master drives the shared address/control bus. It uses fixed-priority arbitration and holds the grant for locked transfers and fixed-length bursts. It consumes the slave HRESP/HSPLIT handshake: a master answered with SPLIT is masked out of arbitration until a slave releases it through HSPLIT.

Parameters:
NUM_MASTERS, 4, number of masters; index 0 has highest priority.
DEFAULT_MASTER, 3, master granted when no eligible master requests.
MW, $clog2(NUM_MASTERS), width of HMASTER.

Ports:
HCLK  in  1  bus clock, rising edge.
HRESETN  in  1  asynchronous active-low reset.
HBUSREQ  in  NUM_MASTERS  bus request per master.
HLOCK  in  NUM_MASTERS  lock request per master.
HTRANS  in  2  muxed transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
HBURST  in  3  muxed burst type: SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7.
HREADY  in  1  bus ready (muxed from the selected slave).
HRESP  in  2  muxed slave response: OKAY=0, ERROR=1, RETRY=2, SPLIT=3.
HSPLIT  in  NUM_MASTERS  OR of all slave HSPLIT vectors; bit i releases master i.
HGRANT  out  NUM_MASTERS  one-hot grant.
HMASTER  out  MW  address-phase owner.
HMASTLOCK  out  1  current address phase is locked.

Behaviour:
- Reset is asynchronous and active-low; the clock is the single edge for all state. While HRESETN=0:
  - HGRANT = one-hot(DEFAULT_MASTER), HMASTER = DEFAULT_MASTER, HMASTLOCK = 0.
  - Split mask = 0, beat counter = 0, data-phase master = DEFAULT_MASTER.
- Data-phase owner: dmaster <= HMASTER on each edge with HREADY=1.
- Address-phase owner: HMASTER <= index(HGRANT) and HMASTLOCK <= HLOCK[index(HGRANT)] on each edge with HREADY=1. Both hold while HREADY=0.
- Beat counter (address phase of HMASTER), updated only on edges with HREADY=1:
  - HTRANS=NONSEQ with HBURST WRAP4/INCR4: load 3; WRAP8/INCR8: load 7; WRAP16/INCR16: load 15; SINGLE/INCR: load 0.
  - HTRANS=SEQ with count>0: decrement.
  - IDLE/BUSY: hold.
- Early termination: a cycle with HRESP in {ERROR, RETRY, SPLIT} and HREADY=0 (first cycle of the two-cycle response) forces the counter to 0.
- Split mask:
  - A cycle with HRESP=SPLIT and HREADY=0 sets mask[dmaster].
  - HSPLIT[i]=1 clears mask[i].
  - If set and clear hit the same bit in the same cycle, set wins.
  - RETRY does not mask.
- Eligible = HBUSREQ & ~mask.
- Re-arbitration is permitted in a cycle when count==0 and the granted master does not have (HLOCK and HBUSREQ) asserted. An early-termination cycle always permits re-arbitration.
- When permitted, HGRANT <= one-hot(lowest index set in eligible). If eligible==0, HGRANT <= one-hot(DEFAULT_MASTER), even if that master is masked.
- When not permitted, HGRANT holds.
- HGRANT is registered, so latency is 1 clock from request to grant. Ownership (HMASTER) changes on the first HREADY=1 edge after the grant changes.
- HGRANT is always exactly one-hot; there is no zero-grant state.
- During a locked sequence the locked master keeps the grant even when it is split-masked. Its mask bit still sets, and the grant is lost only when HLOCK deasserts.

Test Plan:
- Reset: HRESETN=0 -> HGRANT=4'b1000, HMASTER=3, HMASTLOCK=0. Release and hold HBUSREQ=0 -> HGRANT stays 4'b1000.
- Priority: HBUSREQ=4'b0110, HREADY=1 -> HGRANT=4'b0010 after 1 clock, HMASTER=1 one clock later.
- Burst hold: master 2 granted, drives NONSEQ INCR4 then SEQ beats; HBUSREQ[0] rises during beat 2 -> HGRANT stays 4'b0100 until the 4th beat is accepted, then becomes 4'b0001. Variant: RETRY at beat 2 -> HGRANT becomes 4'b0001 after the RETRY cycle.
- Split: master 1 in data phase, HRESP=SPLIT with HREADY=0 then HREADY=1, HBUSREQ=4'b0010 held -> mask=4'b0010, HGRANT=4'b1000. Pulse HSPLIT=4'b0010 for 1 cycle -> HGRANT=4'b0010 on the following edge.
- Lock: master 2 with HLOCK[2]=1 and HBUSREQ[2]=1 granted; HBUSREQ[0] asserted -> HGRANT stays 4'b0100 and HMASTLOCK=1. Deassert HLOCK[2] -> HGRANT=4'b0001.
- Reset mid-burst: assert HRESETN=0 between clock edges during INCR8 -> HGRANT=4'b1000 and HMASTER=3 immediately, with no clock edge required; counter and mask read 0 after release.

Source files
------------

// File: rtl/ahb_split_arbiter.sv
`timescale 1ns/1ps
// ahb_split_arbiter
//   Fixed-priority AHB arbiter (master 0 highest). Holds the grant across
//   locked sequences and fixed-length bursts. Masters answered with SPLIT
//   stay out of arbitration until a slave releases them via HSPLIT.
// Ports:
//   HCLK, HRESETN          clock (rising edge), async active-low reset
//   HBUSREQ, HLOCK         per-master request / lock request
//   HTRANS, HBURST         muxed transfer type and burst type of HMASTER
//   HREADY, HRESP          muxed slave ready / response
//   HSPLIT                 OR of slave split-release vectors
//   HGRANT                 one-hot grant (registered)
//   HMASTER, HMASTLOCK     address-phase owner and its lock status
module ahb_split_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 3,
  parameter int MW             = $clog2(NUM_MASTERS)
) (
  input  logic                   HCLK,
  input  logic                   HRESETN,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  input  logic [1:0]             HRESP,
  input  logic [NUM_MASTERS-1:0] HSPLIT,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MW-1:0]          HMASTER,
  output logic                   HMASTLOCK
);

  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;
  localparam logic [1:0] RSP_OKAY  = 2'd0;
  localparam logic [1:0] RSP_SPLIT = 2'd3;

  localparam logic [NUM_MASTERS-1:0] DEF_GRANT =
    {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;
  localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);

  logic [MW-1:0]          gidx;      // index of the current grant
  logic [MW-1:0]          dmaster;   // data-phase owner
  logic [3:0]             count;     // remaining beats of HMASTER's burst
  logic [NUM_MASTERS-1:0] mask;      // split-masked masters
  logic [NUM_MASTERS-1:0] eligible;
  logic [NUM_MASTERS-1:0] pick;
  logic [NUM_MASTERS-1:0] mask_set;
  logic                   early_term;
  logic                   lock_hold;
  logic                   permit;

  // Remaining beats after the first one; INCR has no fixed length so it
  // never holds the bus.
  function automatic logic [3:0] burst_rem(input logic [2:0] b);
    case (b)
      3'd2, 3'd3: burst_rem = 4'd3;
      3'd4, 3'd5: burst_rem = 4'd7;
      3'd6, 3'd7: burst_rem = 4'd15;
      default:    burst_rem = 4'd0;
    endcase
  endfunction

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (HGRANT[i]) gidx = MW'(i);
  end

  assign eligible = HBUSREQ & ~mask;

  // Lowest eligible index wins; with nobody eligible the default master
  // gets the bus even if it is masked.
  always_comb begin
    pick = DEF_GRANT;
    for (int i = NUM_MASTERS-1; i >= 0; i--)
      if (eligible[i]) begin
        pick    = '0;
        pick[i] = 1'b1;
      end
  end

  // First cycle of a two-cycle ERROR/RETRY/SPLIT response.
  assign early_term = !HREADY && (HRESP != RSP_OKAY);
  // A locked master keeps the bus even through early termination or a split.
  assign lock_hold  = HLOCK[gidx] && HBUSREQ[gidx];
  assign permit     = !lock_hold && ((count == 4'd0) || early_term);

  always_comb begin
    mask_set = '0;
    if (HRESP == RSP_SPLIT && !HREADY) mask_set[dmaster] = 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      HGRANT    <= DEF_GRANT;
      HMASTER   <= DEF_IDX;
      HMASTLOCK <= 1'b0;
      dmaster   <= DEF_IDX;
      count     <= 4'd0;
      mask      <= '0;
    end else begin
      if (permit) HGRANT <= pick;

      if (HREADY) begin
        dmaster   <= HMASTER;
        HMASTER   <= gidx;
        HMASTLOCK <= HLOCK[gidx];
      end

      if (early_term)
        count <= 4'd0;
      else if (HREADY) begin
        if (HTRANS == TR_NONSEQ)
          count <= burst_rem(HBURST);
        else if (HTRANS == TR_SEQ && count != 4'd0)
          count <= count - 4'd1;
      end

      // A set on the same bit as a release wins.
      mask <= (mask & ~HSPLIT) | mask_set;
    end
  end

endmodule

// File: tb/tb_ahb_split_arbiter.sv
`timescale 1ns/1ps
// Bench for ahb_split_arbiter: directed vector table, hand-written
// reset-mid-burst sequence, and random traffic checked against a
// cycle-level reference model.
module tb_ahb_split_arbiter;

  logic       HCLK;
  logic       HRESETN;
  logic [3:0] HBUSREQ, HLOCK, HSPLIT, HGRANT;
  logic [1:0] HTRANS, HRESP, HMASTER;
  logic [2:0] HBURST;
  logic       HREADY, HMASTLOCK;

  ahb_split_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(3)) dut (
    .HCLK(HCLK), .HRESETN(HRESETN), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
    .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY), .HRESP(HRESP),
    .HSPLIT(HSPLIT), .HGRANT(HGRANT), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [3:0] req, lock;
    logic [1:0] trans;
    logic [2:0] burst;
    logic       ready;
    logic [1:0] resp;
    logic [3:0] split;
    logic [3:0] eg;
    logic [1:0] em;
    logic       eml;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  int       m_g, m_hm, m_dm, m_cnt;
  bit       m_ml;
  bit [3:0] m_mask;
  int       beats[8] = '{1, 1, 4, 4, 8, 8, 16, 16};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] req, lock, input logic [1:0] trans,
                              input logic [2:0] burst, input logic ready,
                              input logic [1:0] resp, input logic [3:0] split,
                              input logic [3:0] eg, input logic [1:0] em, input logic eml);
    vec_t v;
    v.req = req; v.lock = lock; v.trans = trans; v.burst = burst; v.ready = ready;
    v.resp = resp; v.split = split; v.eg = eg; v.em = em; v.eml = eml;
    return v;
  endfunction

  task automatic model_reset();
    m_g = 3; m_hm = 3; m_dm = 3; m_ml = 0; m_cnt = 0; m_mask = '0;
  endtask

  // One clock of the arbitration rules, using the inputs seen at the edge.
  task automatic model_step(input vec_t s);
    bit       early, hold;
    bit [3:0] elig, nm;
    int       ng, nc;
    early = !s.ready && s.resp != 2'd0;
    hold  = s.lock[m_g] && s.req[m_g];
    elig  = s.req & ~m_mask;
    ng    = m_g;
    if (!hold && (m_cnt == 0 || early)) begin
      ng = 3;
      for (int i = 3; i >= 0; i--) if (elig[i]) ng = i;
    end
    nm = m_mask & ~s.split;
    if (s.resp == 2'd3 && !s.ready) nm[m_dm] = 1'b1;
    nc = m_cnt;
    if (early) nc = 0;
    else if (s.ready) begin
      if (s.trans == 2'd2) nc = beats[s.burst] - 1;
      else if (s.trans == 2'd3 && m_cnt > 0) nc = m_cnt - 1;
    end
    if (s.ready) begin
      m_dm = m_hm;
      m_hm = m_g;
      m_ml = s.lock[m_g];
    end
    m_g = ng; m_mask = nm; m_cnt = nc;
  endtask

  task automatic apply(input vec_t s);
    HBUSREQ = s.req; HLOCK = s.lock; HTRANS = s.trans; HBURST = s.burst;
    HREADY = s.ready; HRESP = s.resp; HSPLIT = s.split;
  endtask

  // Drive on the falling edge, step the model on the rising edge, settle 1ns.
  task automatic drive(input vec_t s);
    @(negedge HCLK);
    apply(s);
    @(posedge HCLK);
    model_step(s);
    #1;
  endtask

  vec_t tbl[31];
  vec_t z;

  initial begin
    // req    lock   tr bu rdy rsp split    eg     em  eml
    tbl[0]  = mk(4'b0000, 4'b0000, 0, 0, 1, 0, 4'b0000, 4'b1000, 3, 0);
    tbl[1]  = mk(4'b0110, 4'b0000, 0, 0, 1, 0, 4'b0000, 4'b0010, 3, 0);
    tbl[2]  = mk(4'b0110, 4'b0000, 0, 0, 1, 0, 4'b0000, 4'b0010, 1, 0);
    tbl[3]  = mk(4'b0100, 4'b0000, 0, 0, 1, 0, 4'b0000, 4'b0100, 1, 0);
    tbl[4]  = mk(4'b0100, 4'b0000, 0, 0, 1, 0, 4'b0000, 4'b0100, 2, 0);
    // INCR4 by master 2, master 0 requests from beat 2
    tbl[5]  = mk(4'b0100, 4'b0000, 2, 3, 1, 0, 4'b0000, 4'b0100, 2, 0);
    tbl[6]  = mk(4'b0101, 4'b0000, 3, 3, 1, 0, 4'b0000, 4'b0100, 2, 0);
    tbl[7]  = mk(4'b0101, 4'b0000, 3, 3, 1, 0, 4'b0000, 4'b0100, 2, 0);
    tbl[8]  = mk(4'b0101, 4'b0000, 3, 3, 1, 0, 4'b0000, 4'b0100, 2, 0);
    tbl[9]  = mk(4'b0101, 4'b0000, 0, 0, 1, 0, 4'b0000, 4'b0001, 2, 0);
    tbl[10] = mk(4'b0001, 4'b0000, 0, 0, 1, 0, 4'b0000, 4'b0001, 0, 0);
    // INCR4 cut short by RETRY on beat 2
    tbl[11] = mk(4'b0100, 4'b0000, 0, 0, 1, 0, 4'b0000, 4'b0100, 0, 0);
    tbl[12] = mk(4'b0100, 4'b0000, 0, 0, 1, 0, 4'b0000, 4'b0100, 2, 0);
    tbl[13] = mk(4'b0100, 4'b0000, 2, 3, 1, 0, 4'b0000, 4'b0100, 2, 0);
    tbl[14] = mk(4'b0101, 4'b0000, 3, 3, 1, 0, 4'b0000, 4'b0100, 2, 0);
    tbl[15] = mk(4'b0101, 4'b0000, 3, 3, 0, 2, 4'b0000, 4'b0001, 2, 0);
    tbl[16] = mk(4'b0101, 4'b0000, 0, 0, 1, 2, 4'b0000, 4'b0001, 0, 0);
    // SPLIT of master 1, then release via HSPLIT
    tbl[17] = mk(4'b0010, 4'b0000, 0, 0, 1, 0, 4'b0000, 4'b0010, 0, 0);
    tbl[18] = mk(4'b0010, 4'b0000, 0, 0, 1, 0, 4'b0000, 4'b0010, 1, 0);
    tbl[19] = mk(4'b0010, 4'b0000, 2, 0, 1, 0, 4'b0000, 4'b0010, 1, 0);
    tbl[20] = mk(4'b0010, 4'b0000, 0, 0, 0, 3, 4'b0000, 4'b0010, 1, 0);
    tbl[21] = mk(4'b0010, 4'b0000, 0, 0, 1, 3, 4'b0000, 4'b1000, 1, 0);
    tbl[22] = mk(4'b0010, 4'b0000, 0, 0, 1, 0, 4'b0000, 4'b1000, 3, 0);
    tbl[23] = mk(4'b0010, 4'b0000, 0, 0, 1, 0, 4'b0010, 4'b1000, 3, 0);
    tbl[24] = mk(4'b0010, 4'b0000, 0, 0, 1, 0, 4'b0000, 4'b0010, 3, 0);
    tbl[25] = mk(4'b0010, 4'b0000, 0, 0, 1, 0, 4'b0000, 4'b0010, 1, 0);
    // Locked master 2 holds against master 0
    tbl[26] = mk(4'b0100, 4'b0100, 0, 0, 1, 0, 4'b0000, 4'b0100, 1, 0);
    tbl[27] = mk(4'b0101, 4'b0100, 0, 0, 1, 0, 4'b0000, 4'b0100, 2, 1);
    tbl[28] = mk(4'b0101, 4'b0100, 0, 0, 1, 0, 4'b0000, 4'b0100, 2, 1);
    tbl[29] = mk(4'b0101, 4'b0000, 0, 0, 1, 0, 4'b0000, 4'b0001, 2, 0);
    tbl[30] = mk(4'b0001, 4'b0000, 0, 0, 1, 0, 4'b0000, 4'b0001, 0, 0);

    z = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    // Reset state
    HRESETN = 1'b0;
    apply(z);
    repeat (2) @(posedge HCLK);
    #1;
    chk("reset grant", {28'd0, HGRANT}, 32'h8);
    chk("reset hmaster", {30'd0, HMASTER}, 32'd3);
    chk("reset hmastlock", {31'd0, HMASTLOCK}, 32'd0);
    @(negedge HCLK);
    HRESETN = 1'b1;
    model_reset();

    // Directed table
    for (int k = 0; k < 31; k++) begin
      drive(tbl[k]);
      chk($sformatf("row%0d grant", k), {28'd0, HGRANT}, {28'd0, tbl[k].eg});
      chk($sformatf("row%0d hmaster", k), {30'd0, HMASTER}, {30'd0, tbl[k].em});
      chk($sformatf("row%0d hmastlock", k), {31'd0, HMASTLOCK}, {31'd0, tbl[k].eml});
    end

    // Random traffic against the model
    for (int k = 0; k < 600; k++) begin
      vec_t r;
      r = z;
      r.req   = 4'($urandom);
      r.lock  = ($urandom_range(0, 2) == 0) ? (4'($urandom) & r.req) : 4'b0000;
      r.trans = 2'($urandom);
      r.burst = 3'($urandom);
      r.ready = ($urandom_range(0, 4) != 0);
      r.resp  = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'd0;
      r.split = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      drive(r);
      chk($sformatf("rnd%0d grant", k), {28'd0, HGRANT}, 32'd1 << m_g);
      chk($sformatf("rnd%0d hmaster", k), {30'd0, HMASTER}, 32'(m_hm));
      chk($sformatf("rnd%0d hmastlock", k), {31'd0, HMASTLOCK}, {31'd0, m_ml});
      chk($sformatf("rnd%0d mask", k), {28'd0, dut.mask}, {28'd0, m_mask});
      chk($sformatf("rnd%0d count", k), {28'd0, dut.count}, 32'(m_cnt));
      chk($sformatf("rnd%0d onehot", k), {31'd0, $onehot(HGRANT)}, 32'd1);
    end

    // Reset in the middle of an INCR8 with a split mask pending
    begin
      vec_t s;
      s = z; s.ready = 1'b0; s.resp = 2'd3;
      drive(s);
      s.ready = 1'b1;
      drive(s);
      s = z; s.trans = 2'd2; s.burst = 3'd5;
      drive(s);
      s.trans = 2'd3;
      drive(s);
    end
    chk("preburst count", {28'd0, dut.count}, 32'd6);
    chk("preburst mask", {28'd0, dut.mask}, {28'd0, m_mask});
    #2;
    HRESETN = 1'b0;
    #1;
    chk("async grant", {28'd0, HGRANT}, 32'h8);
    chk("async hmaster", {30'd0, HMASTER}, 32'd3);
    chk("async hmastlock", {31'd0, HMASTLOCK}, 32'd0);
    model_reset();
    apply(z);
    @(posedge HCLK);
    #1;
    chk("inreset grant", {28'd0, HGRANT}, 32'h8);
    @(negedge HCLK);
    HRESETN = 1'b1;
    #1;
    chk("postreset count", {28'd0, dut.count}, 32'd0);
    chk("postreset mask", {28'd0, dut.mask}, 32'd0);
    drive(z);
    chk("idle grant", {28'd0, HGRANT}, 32'h8);
    chk("idle hmaster", {30'd0, HMASTER}, 32'd3);
    begin
      vec_t s;
      s = z; s.req = 4'b0010;
      drive(s);
      chk("req1 grant", {28'd0, HGRANT}, 32'h2);
      drive(s);
      chk("req1 hmaster", {30'd0, HMASTER}, 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
